// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned ARB_N_DEF        = 4;
    localparam int unsigned ARB_MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-priority-encode: first set request at or after
// start (wrapping), optionally skipping one excluded index.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    input  logic           excl_en,
    input  logic [IDW-1:0] excl_idx,
    output logic           valid,
    output logic [N-1:0]   onehot,
    output logic [IDW-1:0] idx
);

    logic [N-1:0]   masked;
    logic [IDW-1:0] cand;

    always_comb begin
        masked = req;
        valid  = 1'b0;
        onehot = '0;
        idx    = '0;
        cand   = '0;
        if (excl_en) begin
            masked[excl_idx] = 1'b0;
        end
        for (int unsigned i = 0; i < N; i++) begin
            cand = IDW'((32'(start) + i) % N);
            if (!valid && masked[cand]) begin
                valid        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with registered one-hot grant and zero-bubble handoff.
// Define RR_ARB_TIMEOUT_EN to force rotation after MAX_HOLD consecutive grant cycles.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N        = ARB_N_DEF,
    parameter int unsigned MAX_HOLD = ARB_MAX_HOLD_DEF,
    parameter int unsigned IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           preempt
);

    if ((N < 2) || (N > 16) || (MAX_HOLD < 2)) begin : g_bad_cfg
        $error("rr_arbiter: unsupported N or MAX_HOLD");
    end

    arb_state_t     state, state_n;
    logic [N-1:0]   gnt_n;
    logic [IDW-1:0] gnt_id_n;
    logic [IDW-1:0] rr_ptr, rr_ptr_n;
    logic [IDW-1:0] succ;
    logic           busy_n;

    logic           idle_valid, hand_valid;
    logic [N-1:0]   idle_oh, hand_oh;
    logic [IDW-1:0] idle_idx, hand_idx;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt, hold_n;
    logic          preempt_n;
`endif

    assign succ = IDW'((32'(gnt_id) + 32'd1) % N);

    rr_pick #(.N(N), .IDW(IDW)) u_idle_pick (
        .req      (req),
        .start    (rr_ptr),
        .excl_en  (1'b0),
        .excl_idx ({IDW{1'b0}}),
        .valid    (idle_valid),
        .onehot   (idle_oh),
        .idx      (idle_idx)
    );

    // Handoff pick: scan from the owner's successor, owner excluded.
    rr_pick #(.N(N), .IDW(IDW)) u_hand_pick (
        .req      (req),
        .start    (succ),
        .excl_en  (1'b1),
        .excl_idx (gnt_id),
        .valid    (hand_valid),
        .onehot   (hand_oh),
        .idx      (hand_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt <= '0;
            preempt  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            gnt_id   <= gnt_id_n;
            busy     <= busy_n;
            rr_ptr   <= rr_ptr_n;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt <= hold_n;
            preempt  <= preempt_n;
`endif
        end
    end

`ifndef RR_ARB_TIMEOUT_EN
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        rr_ptr_n  = rr_ptr;
`ifdef RR_ARB_TIMEOUT_EN
        hold_n    = hold_cnt;
        preempt_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (idle_valid) begin
                    state_n  = GRANT;
                    gnt_n    = idle_oh;
                    gnt_id_n = idle_idx;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_n   = HW'(1);
`endif
                end
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    rr_ptr_n = succ;
                    if (hand_valid) begin
                        gnt_n    = hand_oh;
                        gnt_id_n = hand_idx;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_n   = HW'(1);
`endif
                    end else begin
                        state_n  = IDLE;
                        gnt_n    = '0;
                        gnt_id_n = '0;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_n   = '0;
`endif
                    end
                end
`ifdef RR_ARB_TIMEOUT_EN
                // At the hold limit the owner yields only if someone else is waiting.
                else if (hold_cnt == HW'(MAX_HOLD)) begin
                    if (hand_valid) begin
                        rr_ptr_n  = succ;
                        gnt_n     = hand_oh;
                        gnt_id_n  = hand_idx;
                        hold_n    = HW'(1);
                        preempt_n = 1'b1;
                    end
                end else begin
                    hold_n = hold_cnt + HW'(1);
                end
`endif
            end
            default: state_n = IDLE;
        endcase
        busy_n = |gnt_n;
    end

    a_gnt_ok: assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt) && (busy ? (gnt == (N'(1) << gnt_id)) : (gnt_id == '0)));

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (N=4, MAX_HOLD=8); honours RR_ARB_TIMEOUT_EN.
module tb_rr_arbiter;

    localparam int NN = 4;
    localparam int MH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NN-1:0] req = '0;
    logic [NN-1:0] gnt;
    logic [1:0]    gnt_id;
    logic          busy;
    logic          preempt;

    int tests = 0;
    int fails = 0;

    // Reference state: owner index (-1 when idle), rotation pointer, hold length.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_pre   = 1'b0;

    rr_arbiter #(.N(NN), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    function automatic int scan(input logic [NN-1:0] v, input int start);
        for (int k = 0; k < NN; k++) begin
            if (v[(start + k) % NN]) return (start + k) % NN;
        end
        return -1;
    endfunction

    task automatic model_update(input logic [NN-1:0] r, input logic rs);
        logic [NN-1:0] others;
        m_pre = 1'b0;
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_hold = 0;
        end else if (m_owner < 0) begin
            if (r != '0) begin
                m_owner = scan(r, m_ptr);
                m_hold  = 1;
            end
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                m_ptr = (m_owner + 1) % NN;
                if (others != '0) begin
                    m_owner = scan(others, m_ptr);
                    m_hold  = 1;
                end else begin
                    m_owner = -1;
                    m_hold  = 0;
                end
            end else begin
`ifdef RR_ARB_TIMEOUT_EN
                if (m_hold == MH && others != '0) begin
                    m_ptr   = (m_owner + 1) % NN;
                    m_owner = scan(others, m_ptr);
                    m_hold  = 1;
                    m_pre   = 1'b1;
                end else if (m_hold < MH) begin
                    m_hold++;
                end
`endif
            end
        end
    endtask

    function automatic logic [NN-1:0] e_gnt();
        return (m_owner < 0) ? '0 : NN'(1 << m_owner);
    endfunction

    function automatic logic [1:0] e_id();
        return (m_owner < 0) ? 2'd0 : 2'(m_owner);
    endfunction

    // Apply inputs, take one rising edge, advance the model, settle.
    task automatic step(input logic [NN-1:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        model_update(r, rs);
        #1;
    endtask

    task automatic test_reset();
        step(4'b0000, 1'b1);
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        tests++; if (gnt_id !== 2'd0) begin fails++; $display("FAIL reset_id: got %0d want 0", gnt_id); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (preempt !== 1'b0) begin fails++; $display("FAIL reset_preempt: got %b want 0", preempt); end
    endtask

    task automatic test_reset_mid_grant();
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL rstmid_pre: got %b want 0100", gnt); end
        step(4'b0100, 1'b1);
        tests++; if (gnt !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_drop: got gnt=%b busy=%b want 0000/0", gnt, busy); end
        step(4'b1111, 1'b0);
        tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL rstmid_first: got %b want 0001", gnt); end
    endtask

    task automatic test_single();
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        tests++; if (gnt !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1) begin fails++; $display("FAIL single_grant: got gnt=%b id=%0d busy=%b want 0100/2/1", gnt, gnt_id, busy); end
        step(4'b0000, 1'b0);
        tests++; if (gnt !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL single_release: got gnt=%b busy=%b want 0000/0", gnt, busy); end
    endtask

    task automatic test_back_to_back();
        int o;
        logic [NN-1:0] drop;
        step(4'b0000, 1'b1);
        step(4'b1111, 1'b0);
        tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL rot_first: got %b want 0001", gnt); end
        o = 0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 2; c++) begin
                step(4'b1111, 1'b0);
                tests++; if (gnt !== NN'(1 << o)) begin fails++; $display("FAIL rot_hold owner %0d: got %b", o, gnt); end
            end
            drop = 4'b1111;
            drop[o] = 1'b0;
            step(drop, 1'b0);
            o = (o + 1) % NN;
            tests++; if (gnt !== NN'(1 << o) || gnt_id !== 2'(o) || busy !== 1'b1) begin fails++; $display("FAIL rot_handoff: got gnt=%b id=%0d busy=%b want owner %0d", gnt, gnt_id, busy, o); end
        end
    endtask

    task automatic test_wrap_skip();
        step(4'b0000, 1'b1);
        step(4'b1000, 1'b0);
        tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL wrap_setup: got %b want 1000", gnt); end
        step(4'b0101, 1'b0);
        tests++; if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin fails++; $display("FAIL wrap: got gnt=%b id=%0d want 0001/0", gnt, gnt_id); end
        step(4'b0100, 1'b0);
        tests++; if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin fails++; $display("FAIL skip: got gnt=%b id=%0d want 0100/2", gnt, gnt_id); end
    endtask

    task automatic test_timeout();
        step(4'b0000, 1'b1);
`ifdef RR_ARB_TIMEOUT_EN
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < MH; c++) begin
                step(4'b0011, 1'b0);
                tests++; if (gnt !== 4'b0001 || preempt !== ((r == 1 && c == 0) ? 1'b1 : 1'b0)) begin fails++; $display("FAIL to_owner0 round %0d cyc %0d: got gnt=%b pre=%b", r, c, gnt, preempt); end
            end
            for (int c = 0; c < MH; c++) begin
                step(4'b0011, 1'b0);
                tests++; if (gnt !== 4'b0010 || preempt !== (c == 0 ? 1'b1 : 1'b0)) begin fails++; $display("FAIL to_owner1 round %0d cyc %0d: got gnt=%b pre=%b", r, c, gnt, preempt); end
            end
        end
        step(4'b0001, 1'b1);
        for (int c = 0; c < 30; c++) begin
            step(4'b0001, 1'b0);
            tests++; if (gnt !== 4'b0001 || preempt !== 1'b0) begin fails++; $display("FAIL to_alone cyc %0d: got gnt=%b pre=%b want 0001/0", c, gnt, preempt); end
        end
`else
        for (int c = 0; c < 120; c++) begin
            step(4'b0011, 1'b0);
            tests++; if (gnt !== 4'b0001 || preempt !== 1'b0) begin fails++; $display("FAIL hold cyc %0d: got gnt=%b pre=%b want 0001/0", c, gnt, preempt); end
        end
`endif
    endtask

    task automatic test_random();
        logic [NN-1:0] cur;
        logic          rs;
        cur = '0;
        step(4'b0000, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) cur = cur ^ (NN'(1) << $urandom_range(NN - 1));
            rs = ($urandom_range(249) == 0);
            step(cur, rs);
            tests++; if (gnt !== e_gnt()) begin fails++; $display("FAIL rnd_gnt cyc %0d req %b: got %b want %b", c, cur, gnt, e_gnt()); end
            tests++; if (gnt_id !== e_id()) begin fails++; $display("FAIL rnd_id cyc %0d: got %0d want %0d", c, gnt_id, e_id()); end
            tests++; if (busy !== (m_owner >= 0)) begin fails++; $display("FAIL rnd_busy cyc %0d: got %b want %b", c, busy, (m_owner >= 0)); end
            tests++; if (preempt !== m_pre) begin fails++; $display("FAIL rnd_preempt cyc %0d: got %b want %b", c, preempt, m_pre); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid_grant();
        test_back_to_back();
        test_wrap_skip();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
